axis_fwft_fifo: RTL and testbench

- Small synchronous first-word-fall-through (FWFT) FIFO used as the input buffer of AXI-Stream packet-processing blocks.
- A stream's {tlast, tuser, tkeep, tdata} is packed into one word on the write side.
- The head word is presented combinationally on dout whenever the FIFO is non-empty; rd_en pops it.
- nearly_full drives upstream tready (tready = !nearly_full), leaving one slot of slack for a write already in flight.

---
 rtl/axis_fwft_fifo_pkg.sv | 27 ++
 rtl/fifo_storage_ram.sv | 39 +++
 rtl/axis_fwft_fifo.sv | 116 +++++++++++
 tb/tb_axis_fwft_fifo.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/axis_fwft_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axis_fwft_fifo_pkg
//  Purpose  : Shared utility package for the stream blocks (sizing helpers).
//  Revision : 1.0 - initial release
// ============================================================================
package axis_fwft_fifo_pkg;

  // Ceiling log2, clamped to at least 1 so a one-entry array still gets a
  // usable address bit.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_storage_ram.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_storage_ram
//  Purpose  : WIDTH x DEPTH register array, one synchronous write port and
//             one asynchronous (combinational) read port.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_storage_ram
  import axis_fwft_fifo_pkg::*;
#(
  parameter int WIDTH  = 72,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  // Contents are deliberately not reset; validity is tracked by the owner.
  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: capture on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: combinational so the head word falls through immediately.
  always_comb begin
    rdata = mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/axis_fwft_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : axis_fwft_fifo
//  Purpose  : First-word-fall-through FIFO used as the input buffer of
//             AXI-Stream blocks. Head word is always visible on dout while
//             non-empty; rd_en pops it. nearly_full leaves one slot of slack
//             for a write already in flight upstream.
//  Revision : 1.0 - initial release
// ============================================================================
module axis_fwft_fifo
  import axis_fwft_fifo_pkg::*;
#(
  parameter int WIDTH               = 72,
  parameter int MAX_DEPTH_BITS      = 3,
  parameter int PROG_FULL_THRESHOLD = 2**MAX_DEPTH_BITS - 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             nearly_full,
  output logic             prog_full,
  output logic             empty
);

  localparam int DEPTH = 2**MAX_DEPTH_BITS;
  localparam int PW    = MAX_DEPTH_BITS;
  localparam int CW    = MAX_DEPTH_BITS + 1;

  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
  localparam logic [CW-1:0] NEAR_C      = CW'(DEPTH - 1);
  localparam logic [CW-1:0] PROG_C      = CW'(PROG_FULL_THRESHOLD);
  localparam logic [CW-1:0] ONE_C       = CW'(1);
  localparam logic [PW-1:0] PTR_ONE_C   = PW'(1);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          wr_accept;
  logic          rd_accept;

  // Acceptance: a full FIFO drops writes even when a read frees a slot in the
  // same cycle; an empty FIFO ignores reads even when a write lands.
  always_comb begin
    wr_accept = wr_en & ~full;
    rd_accept = rd_en & ~empty;
  end

  // Occupancy: only a lone accepted write or read moves the count.
  always_comb begin
    count_next = count;
    case ({wr_accept, rd_accept})
      2'b10:   count_next = count + ONE_C;
      2'b01:   count_next = count - ONE_C;
      default: count_next = count;
    endcase
  end

  // Pointer and count registers; reset discards all contents at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_ONE_C;
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + PTR_ONE_C;
      end
      count <= count_next;
    end
  end

  // Status flags decoded from the registered count.
  always_comb begin
    empty       = (count == '0);
    full        = (count == DEPTH_C);
    nearly_full = (count >= NEAR_C);
    prog_full   = (count >= PROG_C);
  end

  fifo_storage_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (PW)
  ) u_storage (
    .clk   (clk),
    .we    (wr_accept),
    .waddr (wr_ptr),
    .wdata (din),
    .raddr (rd_ptr),
    .rdata (dout)
  );

`ifndef SYNTHESIS
  // Simulation warnings for requests that the FIFO discards.
  always_ff @(posedge clk) begin
    if (resetn) begin
      if (wr_en && full) begin
        $display("axis_fwft_fifo warning: write dropped while full at %0t", $time);
      end
      if (rd_en && empty) begin
        $display("axis_fwft_fifo warning: read ignored while empty at %0t", $time);
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_fwft_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_fwft_fifo
//  Purpose  : Scoreboard bench for axis_fwft_fifo (WIDTH=8, DEPTH=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axis_fwft_fifo;

  localparam int W = 8;

  logic         clk;
  logic         resetn;
  logic [W-1:0] din;
  logic         wr_en;
  logic         rd_en;
  logic [W-1:0] dout;
  logic         full;
  logic         nearly_full;
  logic         prog_full;
  logic         empty;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] sb[$];

  axis_fwft_fifo #(
    .WIDTH               (W),
    .MAX_DEPTH_BITS      (2),
    .PROG_FULL_THRESHOLD (3)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .din         (din),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .dout        (dout),
    .full        (full),
    .nearly_full (nearly_full),
    .prog_full   (prog_full),
    .empty       (empty)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic chk_flags(input string name, input logic e, input logic f,
                           input logic nf, input logic pf);
    check({name, ".empty"},       32'(empty),       32'(e));
    check({name, ".full"},        32'(full),        32'(f));
    check({name, ".nearly_full"}, 32'(nearly_full), 32'(nf));
    check({name, ".prog_full"},   32'(prog_full),   32'(pf));
  endtask

  // Drive one cycle of stimulus, then return 1 ns after the active edge.
  task automatic step(input logic w, input logic [W-1:0] d, input logic r);
    wr_en = w;
    din   = d;
    rd_en = r;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  // Monitor: every pop that the DUT will accept must match the queue head.
  always @(negedge clk) begin
    if (resetn && rd_en && !empty) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop: got %0h required no-data", dout);
      end else begin
        check("pop", 32'(dout), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    resetn = 1'b0;
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    din    = '0;

    // Reset held for 3 cycles
    repeat (3) @(posedge clk);
    #1;
    chk_flags("in_reset", 1'b1, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk_flags("after_reset", 1'b1, 1'b0, 1'b0, 1'b0);

    // FWFT: word visible right after the write edge, no rd_en needed
    sb.push_back(8'hA1);
    step(1'b1, 8'hA1, 1'b0);
    check("fwft.empty", 32'(empty), 32'd0);
    check("fwft.dout",  32'(dout),  32'hA1);
    step(1'b0, 8'h00, 1'b1);
    check("fwft_pop.empty", 32'(empty), 32'd1);

    // Fill, overflow drop, drain
    for (int i = 1; i <= 4; i++) begin
      sb.push_back(8'(8'h11 * i));
      step(1'b1, 8'(8'h11 * i), 1'b0);
      if (i == 3) chk_flags("fill3", 1'b0, 1'b0, 1'b1, 1'b1);
    end
    chk_flags("fill4", 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 8'h55, 1'b0);
    chk_flags("drop55", 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (4) step(1'b0, 8'h00, 1'b1);
    chk_flags("drained", 1'b1, 1'b0, 1'b0, 1'b0);

    // Full with simultaneous write and read: read wins, 0x66 dropped
    for (int i = 1; i <= 4; i++) begin
      sb.push_back(8'(8'h11 * i));
      step(1'b1, 8'(8'h11 * i), 1'b0);
    end
    step(1'b1, 8'h66, 1'b1);
    chk_flags("full_wr_rd", 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (3) step(1'b0, 8'h00, 1'b1);
    chk_flags("drained2", 1'b1, 1'b0, 1'b0, 1'b0);

    // Empty with simultaneous write and read: write wins
    sb.push_back(8'h77);
    step(1'b1, 8'h77, 1'b1);
    chk_flags("empty_wr_rd", 1'b0, 1'b0, 1'b0, 1'b0);
    check("empty_wr_rd.dout", 32'(dout), 32'h77);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk_flags("rd_on_empty", 1'b1, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset with two words held
    step(1'b1, 8'hB1, 1'b0);
    step(1'b1, 8'hB2, 1'b0);
    check("hold2.empty", 32'(empty), 32'd0);
    #1;
    resetn = 1'b0;
    #1;
    chk_flags("async_reset", 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk_flags("after_async", 1'b1, 1'b0, 1'b0, 1'b0);

    // Streaming with wrap: 2-word prefill, then one in / one out per cycle
    sb.push_back(8'hE0);
    step(1'b1, 8'hE0, 1'b0);
    sb.push_back(8'hE1);
    step(1'b1, 8'hE1, 1'b0);
    for (int i = 0; i < 64; i++) begin
      sb.push_back(8'(i));
      step(1'b1, 8'(i), 1'b1);
      chk_flags("stream", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    repeat (2) step(1'b0, 8'h00, 1'b1);
    chk_flags("stream_drained", 1'b1, 1'b0, 1'b0, 1'b0);
    check("scoreboard_left", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Pending words are discarded along with the DUT contents on reset.
  always @(negedge resetn) sb.delete();

endmodule
`default_nettype wire
